// File: rtl/int_acc_pipe.sv
// Single-stage accumulator/branch pipeline: one request per cycle, registered
// result with {N,Z} flags and a resolved true/false next-node destination.
module int_acc_pipe #(
  parameter int DW    = 32,
  parameter int NACC  = 16,
  parameter int NSYS  = 8,
  parameter int NODEW = 16,
  localparam int AW   = (NACC > 1) ? $clog2(NACC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      opr0,
  input  logic [2:0]         op,
  input  logic [AW-1:0]      acc_sel,
  input  logic [3:0]         sys_sel,
  input  logic [NSYS*DW-1:0] sysreg,
  input  logic [1:0]         cc,
  input  logic               cppkt,
  input  logic               t_next_lr,
  input  logic               f_next_lr,
  input  logic [NODEW-1:0]   t_next_node,
  input  logic [NODEW-1:0]   f_next_node,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      rslt,
  output logic [1:0]         flags,
  output logic               next_lr,
  output logic [NODEW-1:0]   next_node
);

  // Handshake: a request transfers on a rising edge with in_valid && in_ready;
  // a result transfers on a rising edge with out_valid && out_ready. The output
  // register frees up in the same cycle it is drained, so in_ready never bubbles.
  localparam logic [2:0] OP_READ  = 3'b001;
  localparam logic [2:0] OP_WRITE = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_SYS   = 3'b100;
  localparam logic [2:0] OP_CMP   = 3'b101;
  localparam logic [2:0] OP_CLR   = 3'b110;

  logic [DW-1:0] acc [NACC];
  logic          accept;
  logic [DW-1:0] acc_val;
  logic [DW-1:0] sys_val;
  logic [DW-1:0] res;
  logic          flag_op;
  logic [1:0]    flags_nx;
  logic          br_true;
  logic          take_t;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign acc_val  = acc[acc_sel];

  // Out-of-range sysreg indices read as zero.
  always_comb begin
    sys_val = '0;
    for (int k = 0; k < NSYS; k++) begin
      if (sys_sel == 4'(k)) sys_val = sysreg[k*DW +: DW];
    end
  end

  always_comb begin
    res = opr0;
    case (op)
      OP_READ:  res = acc_val;
      OP_WRITE: res = opr0;
      OP_ADD:   res = acc_val + opr0;
      OP_SYS:   res = sys_val;
      OP_CMP:   res = acc_val - opr0;
      OP_CLR:   res = '0;
      default:  res = opr0;
    endcase
  end

  // Branch resolves on the flags this request produces, not the old ones.
  always_comb begin
    flag_op  = (op == OP_READ) || (op == OP_ADD) || (op == OP_CMP);
    flags_nx = flag_op ? {res[DW-1], (res == '0)} : flags;
    br_true  = 1'b1;
    if (flag_op) begin
      case (cc)
        2'b01:   br_true = !flags_nx[0];
        2'b10:   br_true = !flags_nx[1];
        default: br_true = 1'b1;
      endcase
    end
    take_t = br_true && !cppkt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      rslt      <= '0;
      flags     <= '0;
      next_lr   <= 1'b0;
      next_node <= '0;
      for (int i = 0; i < NACC; i++) acc[i] <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        rslt      <= res;
        flags     <= flags_nx;
        next_lr   <= take_t ? t_next_lr : f_next_lr;
        next_node <= take_t ? t_next_node : f_next_node;
        if (op == OP_WRITE || op == OP_ADD || op == OP_CLR) acc[acc_sel] <= res;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/int_acc_pipe.md
INT_ACC_PIPE -- requirements
Module: int_acc_pipe

Parameters
REQ-001 SHALL provide DW, default 32: data and accumulator width.
REQ-002 SHALL provide NACC, default 16: accumulator count; power of two, 2..64.
REQ-003 SHALL provide NSYS, default 8: system-register count, 1..16.
REQ-004 SHALL provide NODEW, default 16: next-node field width.

Interface
REQ-005 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1: request present.
REQ-008 SHALL have port in_ready, output, 1: stage can accept.
REQ-009 SHALL have port opr0, input, DW: operand.
REQ-010 SHALL have port op, input, 3: 000 pass, 001 acc read, 010 acc write, 011 acc add, 100 sysreg read, 101 acc compare, 110 acc clear, 111 pass.
REQ-011 SHALL have port acc_sel, input, log2(NACC): accumulator index.
REQ-012 SHALL have port sys_sel, input, 4: sysreg index.
REQ-013 SHALL have port sysreg, input, NSYS*DW: flat sysreg bus, entry k at [k*DW +: DW].
REQ-014 SHALL have port cc, input, 2: branch condition.
REQ-015 SHALL have port cppkt, input, 1: force false path.
REQ-016 SHALL have ports t_next_lr and f_next_lr, input, 1 each: true/false L/R.
REQ-017 SHALL have ports t_next_node and f_next_node, input, NODEW each: true/false next node.
REQ-018 SHALL have port out_valid, output, 1: result present.
REQ-019 SHALL have port out_ready, input, 1: consumer accepts.
REQ-020 SHALL have port rslt, output, DW: result.
REQ-021 SHALL have port flags, output, 2: {N,Z} sticky flag register.
REQ-022 SHALL have ports next_lr, output, 1, and next_node, output, NODEW: resolved destination.

Function
REQ-023 SHALL accept a request on a rising edge when in_valid=1 and in_ready=1.
REQ-024 SHALL drive in_ready = !out_valid | out_ready (combinational, no bubble under full throughput).
REQ-025 SHALL register all result outputs; latency SHALL be 1 cycle from accept to out_valid=1.
REQ-026 SHALL hold out_valid and all output values stable while out_valid=1 and out_ready=0.
REQ-027 SHALL clear out_valid on an edge with out_ready=1 and no accept.
REQ-028 SHALL compute rslt per op: pass=opr0; read=acc[sel]; write=opr0; add=acc[sel]+opr0 mod 2^DW; sysreg=entry sys_sel, or 0 if sys_sel>=NSYS; compare=acc[sel]-opr0 mod 2^DW; clear=0.
REQ-029 SHALL update acc[sel] on the accept edge only: write sets opr0, add sets the sum, clear sets 0; other ops leave all accumulators unchanged.
REQ-030 SHALL let a request accepted the cycle after a write see the new accumulator value (no hazard).
REQ-031 SHALL update flags on accept for ops 001, 011, 101 only: N=rslt[DW-1], Z=(rslt==0); other ops SHALL hold flags.
REQ-032 SHALL evaluate the branch on the new flags: cc 00/11 true; 01 true iff Z=0; 10 true iff N=0; cc SHALL be ignored (true) for ops outside 001/011/101.
REQ-033 SHALL select f_next_node, f_next_lr when branch false or cppkt=1; otherwise t_next_node, t_next_lr.

Reset
REQ-034 SHALL, while rst=1, force out_valid=0, rslt=0, flags=00, next_lr=0, next_node=0 and all accumulators to 0, asynchronously.
REQ-035 SHALL discard an in-flight result and perform no accumulator write on any edge where rst=1.
REQ-036 SHALL accept requests on the first edge after rst deasserts.

Verification
REQ-037 SHALL be verified by: write acc3=5, then add acc3 with opr0=7 -> rslt=12, flags=00, acc3=12.
REQ-038 SHALL be verified by: acc0=0xFFFFFFFF, add opr0=1 -> rslt=0, Z=1, wrap-around without carry.
REQ-039 SHALL be verified by: compare acc1=4 with opr0=9 and cc=10 -> N=1, false path, next_node=f_next_node; the same with cppkt=1 and cc=00 -> false path.
REQ-040 SHALL be verified by: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen, no accumulator change; release -> back-to-back 1-per-cycle throughput.
REQ-041 SHALL be verified by: sys_sel=9 with NSYS=8 -> rslt=0 and flags held.
REQ-042 SHALL be verified by: rst pulse between a write accept and the out_ready edge -> out_valid=0 and all accumulators 0 after reset.
